uart_burst_tx: RTL



---
 rtl/uart_burst_pkg.sv | 17 +
 rtl/uart_burst_tx_bit_timer.sv | 29 ++
 rtl/uart_burst_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_burst_pkg.sv
// Shared types and constants for the burst UART transmitter.
package uart_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_GAP_UNIT     = 100000;
    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;

endpackage

// File: rtl/uart_burst_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Wraps on bit_end so back-to-back bits and frames need no extra clear cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_burst_tx.sv
// Burst UART transmitter: sends num_of_bytes incrementing bytes (8N1, LSB first)
// with an optional idle gap between bytes; all outputs are registered.
module uart_burst_tx
    import uart_burst_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int GAP_UNIT     = DEFAULT_GAP_UNIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] num,
    input  logic [7:0] speed,
    input  logic [7:0] num_of_bytes,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] byte_count
);

    localparam int GAP_W = $clog2(255 * GAP_UNIT + 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       cur_byte;
    logic [7:0]       gap_len;
    logic [7:0]       remaining;
    logic [7:0]       count_int;
    logic [2:0]       bit_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_total;
    logic             gap_last;
    logic             done_flag;
    logic             bit_end;
    logic             timer_clear;
    logic             tx_next;
    logic             busy_next;

    assign timer_clear = (state == IDLE) || (state == GAP);
    assign gap_total   = GAP_W'(gap_len) * GAP_W'(GAP_UNIT);
    assign gap_last    = (gap_cnt == gap_total - GAP_W'(1));

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (num_of_bytes != 8'd0)) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'(DATA_BITS - 1))) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (remaining == 8'd1) begin
                        state_next = IDLE;
                    end else if (gap_len == 8'd0) begin
                        state_next = START;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_next = START;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst datapath; done_flag and count_int are staged so they reach the
    // pins in the same cycle as the registered tx/busy they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_byte  <= '0;
            gap_len   <= '0;
            remaining <= '0;
            count_int <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            done_flag <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            if (state == IDLE && start) begin
                cur_byte  <= num;
                gap_len   <= speed;
                remaining <= num_of_bytes;
                count_int <= '0;
                if (num_of_bytes == 8'd0) begin
                    done_flag <= 1'b1;
                end
            end
            if (state == DATA && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == STOP && bit_end) begin
                count_int <= count_int + 8'd1;
                remaining <= remaining - 8'd1;
                cur_byte  <= cur_byte + 8'd1;
                if (remaining == 8'd1) begin
                    done_flag <= 1'b1;
                end
            end
            if (state == GAP && !gap_last) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state != IDLE);
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = cur_byte[bit_idx];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
        end else begin
            tx         <= tx_next;
            busy       <= busy_next;
            done       <= done_flag;
            byte_count <= count_int;
        end
    end

endmodule
